// File: rtl/alu_issue_seq_pkg.sv
// Shared definitions for the ALU issue sequencer: op class/subop codes,
// FSM state encoding and instruction word field layout.
package alu_issue_seq_pkg;

  localparam logic [1:0] CLS_ARITH   = 2'b00;
  localparam logic [1:0] CLS_LOGIC   = 2'b01;
  localparam logic [1:0] CLS_ZERO    = 2'b10;
  localparam logic [1:0] CLS_SPECIAL = 2'b11;

  localparam logic [1:0] SUB_SHR = 2'b00;
  localparam logic [1:0] SUB_SHL = 2'b01;
  localparam logic [1:0] SUB_ADD = 2'b10;
  localparam logic [1:0] SUB_SUB = 2'b11;

  localparam logic [1:0] SUB_AND = 2'b00;
  localparam logic [1:0] SUB_OR  = 2'b01;
  localparam logic [1:0] SUB_XOR = 2'b10;
  localparam logic [1:0] SUB_ONE = 2'b11;

  localparam int INSTR_W         = 16;
  localparam int INSTR_DEST_LSB  = 14;
  localparam int INSTR_CLASS_LSB = 12;
  localparam int INSTR_SUBOP_LSB = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  // Low ten bits of the instruction word are reserved and always zero.
  function automatic logic [INSTR_W-1:0] encode_instr(input logic [1:0] dest,
                                                      input logic [1:0] cls,
                                                      input logic [1:0] subop);
    return {dest, cls, subop, 10'b0};
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Command and response handshakes between control logic and the sequencer.
interface alu_issue_seq_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_dest;
  logic [1:0] cmd_class;
  logic [1:0] cmd_subop;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_dest;
  logic       rsp_bit;
  logic       rsp_zero;
  logic       rsp_ovf;

  modport master (
    output cmd_valid, cmd_dest, cmd_class, cmd_subop, cmd_a, cmd_b,
    input  cmd_ready,
    input  rsp_valid, rsp_dest, rsp_bit, rsp_zero, rsp_ovf,
    output rsp_ready
  );

  modport slave (
    input  cmd_valid, cmd_dest, cmd_class, cmd_subop, cmd_a, cmd_b,
    output cmd_ready,
    output rsp_valid, rsp_dest, rsp_bit, rsp_zero, rsp_ovf,
    input  rsp_ready
  );

endinterface

// File: rtl/alu_issue_seq.sv
// Issues one ALU operation at a time: drives instruction/operands, waits a
// settle period, captures the selected output and flags, returns a response.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_seq_if.slave     bus,
  output logic [INSTR_W-1:0] instruction,
  output logic [7:0]         data0,
  output logic [7:0]         data1,
  input  logic [3:0]         alu_out,
  input  logic               alu_zero,
  input  logic               alu_ovf,
  output logic [CNT_W-1:0]   op_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       complete;

  logic [1:0] rsp_dest;
  logic       rsp_bit;
  logic       rsp_zero;
  logic       rsp_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept     = 1'b1;
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle_cnt == 4'd0) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture    = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ALU inputs only change on acceptance so they stay stable while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
      data0       <= '0;
      data1       <= '0;
      settle_cnt  <= '0;
    end else if (accept) begin
      instruction <= encode_instr(bus.cmd_dest, bus.cmd_class, bus.cmd_subop);
      data0       <= bus.cmd_a;
      data1       <= bus.cmd_b;
      settle_cnt  <= SETTLE_LOAD;
    end else if (state == ST_DRIVE && settle_cnt != 4'd0) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_dest <= '0;
      rsp_bit  <= 1'b0;
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (capture) begin
      rsp_dest <= instruction[INSTR_DEST_LSB +: 2];
      rsp_bit  <= alu_out[instruction[INSTR_DEST_LSB +: 2]];
      rsp_zero <= alu_zero;
      rsp_ovf  <= alu_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (complete) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_dest  = rsp_dest;
  assign bus.rsp_bit   = rsp_bit;
  assign bus.rsp_zero  = rsp_zero;
  assign bus.rsp_ovf   = rsp_ovf;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: two instances (N=1/CNT_W=16 and N=4/CNT_W=2),
// a transaction-level reference model, directed cases and random traffic.
module tb_alu_issue_seq;
  import alu_issue_seq_pkg::*;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid [NI];
  logic [1:0] cmd_dest  [NI];
  logic [1:0] cmd_class [NI];
  logic [1:0] cmd_subop [NI];
  logic [7:0] cmd_a     [NI];
  logic [7:0] cmd_b     [NI];
  logic       rsp_ready [NI];

  logic        cmd_ready   [NI];
  logic        rsp_valid   [NI];
  logic [1:0]  rsp_dest    [NI];
  logic        rsp_bit     [NI];
  logic        rsp_zero    [NI];
  logic        rsp_ovf     [NI];
  logic [15:0] instruction [NI];
  logic [7:0]  data0       [NI];
  logic [7:0]  data1       [NI];
  logic [15:0] op_count    [NI];

  int checks = 0;
  int errors = 0;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [15:0] cnt_mask(input int i);
    return (i == 0) ? 16'hFFFF : 16'h0003;
  endfunction

  // ALU behaviour: returns {overflow/carry, 8-bit result}.
  function automatic logic [8:0] alu_ref(input logic [1:0] cls, input logic [1:0] sub,
                                         input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    r = 9'd0;
    case (cls)
      CLS_ARITH: begin
        case (sub)
          SUB_SHR: r = {a[0], 1'b0, a[7:1]};
          SUB_SHL: r = {a[7], a[6:0], 1'b0};
          SUB_ADD: r = {1'b0, a} + {1'b0, b};
          default: r = {1'b0, a} - {1'b0, b};
        endcase
      end
      CLS_LOGIC: begin
        case (sub)
          SUB_AND: r = {1'b0, a & b};
          SUB_OR:  r = {1'b0, a | b};
          SUB_XOR: r = {1'b0, a ^ b};
          default: r = 9'h001;
        endcase
      end
      CLS_ZERO: r = 9'h000;
      default:  r = {1'b0, a};
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N  = (g == 0) ? 1 : 4;
    localparam int CW = (g == 0) ? 16 : 2;

    alu_issue_seq_if bus();
    logic [15:0]   instr;
    logic [7:0]    d0;
    logic [7:0]    d1;
    logic [3:0]    alu_out;
    logic          alu_zero;
    logic          alu_ovf;
    logic [8:0]    res;
    logic [3:0]    onehot;
    logic [CW-1:0] cnt;

    assign bus.cmd_valid = cmd_valid[g];
    assign bus.cmd_dest  = cmd_dest[g];
    assign bus.cmd_class = cmd_class[g];
    assign bus.cmd_subop = cmd_subop[g];
    assign bus.cmd_a     = cmd_a[g];
    assign bus.cmd_b     = cmd_b[g];
    assign bus.rsp_ready = rsp_ready[g];

    assign cmd_ready[g]   = bus.cmd_ready;
    assign rsp_valid[g]   = bus.rsp_valid;
    assign rsp_dest[g]    = bus.rsp_dest;
    assign rsp_bit[g]     = bus.rsp_bit;
    assign rsp_zero[g]    = bus.rsp_zero;
    assign rsp_ovf[g]     = bus.rsp_ovf;
    assign instruction[g] = instr;
    assign data0[g]       = d0;
    assign data1[g]       = d1;
    assign op_count[g]    = 16'(cnt);

    // out[dest] carries the result LSB; the other outputs carry its inverse.
    assign res      = alu_ref(instr[INSTR_CLASS_LSB +: 2], instr[INSTR_SUBOP_LSB +: 2], d0, d1);
    assign onehot   = 4'b0001 << instr[INSTR_DEST_LSB +: 2];
    assign alu_out  = res[0] ? onehot : ~onehot;
    assign alu_zero = (res[7:0] == 8'h00);
    assign alu_ovf  = res[8];

    alu_issue_seq #(.SETTLE_CYCLES(N), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .instruction (instr),
      .data0       (d0),
      .data1       (d1),
      .alu_out     (alu_out),
      .alu_zero    (alu_zero),
      .alu_ovf     (alu_ovf),
      .op_count    (cnt)
    );
  end

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL inst%0d %s: got %0h expected %0h at %0t", idx, name, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding op per instance, response due N+1 edges after accept.
  bit          m_pending [NI];
  int          m_wait    [NI];
  logic [15:0] m_instr   [NI];
  logic [7:0]  m_d0      [NI];
  logic [7:0]  m_d1      [NI];
  logic [15:0] m_count   [NI];
  logic [1:0]  m_dest    [NI];
  logic [8:0]  m_res     [NI];
  logic [1:0]  m_rdest   [NI];
  logic        m_rbit    [NI];
  logic        m_rzero   [NI];
  logic        m_rovf    [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_pending[i] <= 1'b0;
        m_wait[i]    <= 0;
        m_instr[i]   <= 16'h0000;
        m_d0[i]      <= 8'h00;
        m_d1[i]      <= 8'h00;
        m_count[i]   <= 16'h0000;
        m_dest[i]    <= 2'b00;
        m_res[i]     <= 9'h000;
        m_rdest[i]   <= 2'b00;
        m_rbit[i]    <= 1'b0;
        m_rzero[i]   <= 1'b0;
        m_rovf[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (m_pending[i]) begin
          if (m_wait[i] == 0) begin
            if (rsp_ready[i]) begin
              m_pending[i] <= 1'b0;
              m_count[i]   <= (m_count[i] + 16'd1) & cnt_mask(i);
            end
          end else begin
            m_wait[i] <= m_wait[i] - 1;
            if (m_wait[i] == 1) begin
              m_rdest[i] <= m_dest[i];
              m_rbit[i]  <= m_res[i][0];
              m_rzero[i] <= (m_res[i][7:0] == 8'h00);
              m_rovf[i]  <= m_res[i][8];
            end
          end
        end else if (cmd_valid[i]) begin
          m_pending[i] <= 1'b1;
          m_wait[i]    <= settle_of(i) + 1;
          m_instr[i]   <= {cmd_dest[i], cmd_class[i], cmd_subop[i], 10'b0};
          m_d0[i]      <= cmd_a[i];
          m_d1[i]      <= cmd_b[i];
          m_dest[i]    <= cmd_dest[i];
          m_res[i]     <= alu_ref(cmd_class[i], cmd_subop[i], cmd_a[i], cmd_b[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      checkOutput("cmd_ready",   i, 16'(cmd_ready[i]), 16'(!m_pending[i]));
      checkOutput("rsp_valid",   i, 16'(rsp_valid[i]), 16'(m_pending[i] && m_wait[i] == 0));
      checkOutput("instruction", i, instruction[i], m_instr[i]);
      checkOutput("data0",       i, 16'(data0[i]), 16'(m_d0[i]));
      checkOutput("data1",       i, 16'(data1[i]), 16'(m_d1[i]));
      checkOutput("op_count",    i, op_count[i], m_count[i]);
      checkOutput("rsp_dest",    i, 16'(rsp_dest[i]), 16'(m_rdest[i]));
      checkOutput("rsp_bit",     i, 16'(rsp_bit[i]), 16'(m_rbit[i]));
      checkOutput("rsp_zero",    i, 16'(rsp_zero[i]), 16'(m_rzero[i]));
      checkOutput("rsp_ovf",     i, 16'(rsp_ovf[i]), 16'(m_rovf[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input logic [1:0] dest, input logic [1:0] cls,
                               input logic [1:0] sub, input logic [7:0] a, input logic [7:0] b);
    cmd_dest[i]  = dest;
    cmd_class[i] = cls;
    cmd_subop[i] = sub;
    cmd_a[i]     = a;
    cmd_b[i]     = b;
    cmd_valid[i] = 1'b1;
  endtask

  task automatic checkRsp(input int i, input logic v, input logic [1:0] d,
                          input logic b, input logic z, input logic o);
    checkOutput("lit_rsp_valid", i, 16'(rsp_valid[i]), 16'(v));
    checkOutput("lit_rsp_dest",  i, 16'(rsp_dest[i]), 16'(d));
    checkOutput("lit_rsp_bit",   i, 16'(rsp_bit[i]), 16'(b));
    checkOutput("lit_rsp_zero",  i, 16'(rsp_zero[i]), 16'(z));
    checkOutput("lit_rsp_ovf",   i, 16'(rsp_ovf[i]), 16'(o));
  endtask

  task automatic checkResetValues();
    for (int i = 0; i < NI; i++) begin
      checkOutput("rst_instruction", i, instruction[i], 16'h0000);
      checkOutput("rst_data0",       i, 16'(data0[i]), 16'h0000);
      checkOutput("rst_data1",       i, 16'(data1[i]), 16'h0000);
      checkOutput("rst_cmd_ready",   i, 16'(cmd_ready[i]), 16'h0001);
      checkOutput("rst_op_count",    i, op_count[i], 16'h0000);
      checkRsp(i, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic waitRsp(input int i, input int budget);
    int n;
    n = 0;
    while (!rsp_valid[i] && n < budget) begin
      tick();
      n++;
    end
    if (!rsp_valid[i]) checkOutput("rsp_timeout", i, 16'h0000, 16'h0001);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen [$];
    int seen_t [$];
    int t;
    logic [15:0] prev;
    logic [15:0] wrap_exp [5];

    for (int i = 0; i < NI; i++) begin
      cmd_valid[i] = 1'b0;
      cmd_dest[i]  = 2'b00;
      cmd_class[i] = 2'b00;
      cmd_subop[i] = 2'b00;
      cmd_a[i]     = 8'h00;
      cmd_b[i]     = 8'h00;
      rsp_ready[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset then idle for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      tick();
      checkResetValues();
    end

    // ADD 05+03 -> 08 on the N=1 instance.
    $display("[TB] add issue");
    rsp_ready[0] = 1'b1;
    applyStimulus(0, 2'd2, CLS_ARITH, SUB_ADD, 8'h05, 8'h03);
    tick();
    cmd_valid[0] = 1'b0;
    checkOutput("lit_instr_add", 0, instruction[0], 16'h8800);
    checkOutput("lit_data0_add", 0, 16'(data0[0]), 16'h0005);
    checkOutput("lit_data1_add", 0, 16'(data1[0]), 16'h0003);
    checkOutput("lit_ready_add", 0, 16'(cmd_ready[0]), 16'h0000);
    tick();
    checkOutput("lit_valid_early", 0, 16'(rsp_valid[0]), 16'h0000);
    tick();
    checkRsp(0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("lit_count_add", 0, op_count[0], 16'h0001);
    checkOutput("lit_valid_done", 0, 16'(rsp_valid[0]), 16'h0000);
    rsp_ready[0] = 1'b0;

    // FF+01 with N=4: carry out and zero result, response 5 cycles after accept.
    $display("[TB] overflow and settle");
    applyStimulus(1, 2'd0, CLS_ARITH, SUB_ADD, 8'hFF, 8'h01);
    tick();
    cmd_valid[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput("lit_ready_settle", 1, 16'(cmd_ready[1]), 16'h0000);
      checkOutput("lit_valid_settle", 1, 16'(rsp_valid[1]), 16'h0000);
      if (c < 4) tick();
    end
    tick();
    checkRsp(1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("lit_ready_resp", 1, 16'(cmd_ready[1]), 16'h0000);
    rsp_ready[1] = 1'b1;
    tick();
    rsp_ready[1] = 1'b0;
    checkOutput("lit_count_ovf", 1, op_count[1], 16'h0001);

    // XOR A5^A4 = 01 held under backpressure while a new command waits.
    $display("[TB] backpressure");
    applyStimulus(0, 2'd1, CLS_LOGIC, SUB_XOR, 8'hA5, 8'hA4);
    tick();
    applyStimulus(0, 2'd3, CLS_ZERO, SUB_AND, 8'h11, 8'h22);
    waitRsp(0, 10);
    for (int c = 0; c < 7; c++) begin
      checkRsp(0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
      checkOutput("lit_instr_stall", 0, instruction[0], 16'h5800);
      checkOutput("lit_ready_stall", 0, 16'(cmd_ready[0]), 16'h0000);
      checkOutput("lit_count_stall", 0, op_count[0], 16'h0001);
      tick();
    end
    rsp_ready[0] = 1'b1;
    cmd_valid[0] = 1'b0;
    tick();
    rsp_ready[0] = 1'b0;
    repeat (3) tick();
    checkOutput("lit_count_bp", 0, op_count[0], 16'h0002);
    checkOutput("lit_instr_hold", 0, instruction[0], 16'h5800);

    // Reset one cycle after accepting a class-11 op.
    $display("[TB] reset mid-drive");
    applyStimulus(1, 2'd2, CLS_SPECIAL, 2'd0, 8'h33, 8'h44);
    tick();
    cmd_valid[1] = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checkResetValues();
    repeat (2) begin
      tick();
      checkResetValues();
    end
    rst_n = 1'b1;
    rsp_ready[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput("lit_no_rsp", 1, 16'(rsp_valid[1]), 16'h0000);
    end

    // Zero-class op to dest 3, back-to-back five times: count wraps at 2 bits.
    $display("[TB] counter wrap");
    applyStimulus(1, 2'd3, CLS_ZERO, 2'd0, 8'h5A, 8'hC3);
    tick();
    checkOutput("lit_instr_zero", 1, instruction[1], 16'hE000);
    prev = op_count[1];
    t = 0;
    while (seen.size() < 5 && t < 60) begin
      tick();
      t++;
      if (op_count[1] != prev) begin
        seen.push_back(int'(op_count[1]));
        seen_t.push_back(t);
        prev = op_count[1];
        if (seen.size() == 5) cmd_valid[1] = 1'b0;
      end
    end
    wrap_exp = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
    checkOutput("wrap_len", 1, 16'(seen.size()), 16'd5);
    for (int k = 0; k < seen.size() && k < 5; k++) begin
      checkOutput("wrap_seq", 1, 16'(seen[k]), wrap_exp[k]);
      if (k > 0) checkOutput("wrap_period", 1, 16'(seen_t[k] - seen_t[k-1]), 16'd7);
    end
    rsp_ready[1] = 1'b0;
    repeat (3) tick();

    // Random traffic on both instances, with one reset pulse.
    $display("[TB] random traffic");
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NI; i++) begin
        cmd_valid[i] = ($urandom_range(0, 2) != 0);
        cmd_dest[i]  = 2'($urandom);
        cmd_class[i] = 2'($urandom);
        cmd_subop[i] = 2'($urandom);
        cmd_a[i]     = 8'($urandom);
        cmd_b[i]     = 8'($urandom);
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      if (c == 1000) rst_n = 1'b0;
      if (c == 1002) rst_n = 1'b1;
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      cmd_valid[i] = 1'b0;
      rsp_ready[i] = 1'b1;
    end
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
